// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the direct-mapped read cache.
// Holds the controller FSM state enum, the word/line geometry and a word-select helper.
// Imported by cache_line_array and cache_controller.
package cache_pkg;

   localparam int WORD_BITS   = 32;
   localparam int LINE_BITS   = 128;
   localparam int OFFSET_BITS = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOOKUP    = 2'd1,
      MISS_WAIT = 2'd2,
      RESP      = 2'd3
   } state_t;

   // Pick the 32-bit word addressed by a byte offset within a line; offset[1:0] is a byte lane and is ignored.
   function automatic logic [WORD_BITS-1:0] word_sel(input logic [LINE_BITS-1:0] line,
                                                     input logic [OFFSET_BITS-1:0] offset);
      return line[offset[3:2]*WORD_BITS +: WORD_BITS];
   endfunction

endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: per-line valid bit, tag and 128-bit data for the direct-mapped cache.
// Combinational read by index; synchronous write on fill.
// Valid bits clear asynchronously on rst_n; tag/data are don't-care until a line is valid.
module cache_line_array
   import cache_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int IDX       = 4,
   parameter int TAG_W     = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IDX-1:0]       rd_idx,
   output logic                 rd_valid,
   output logic [TAG_W-1:0]     rd_tag,
   output logic [LINE_BITS-1:0] rd_data,
   input  logic                 wr_en,
   input  logic [IDX-1:0]       wr_idx,
   input  logic [TAG_W-1:0]     wr_tag,
   input  logic [LINE_BITS-1:0] wr_data
);

   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [LINE_BITS-1:0] data_mem [NUM_LINES];

   // Valid bits: cleared by reset, set when a line is filled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // Tag and data storage: written only on fill, no reset needed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   // Combinational read port used during LOOKUP.
   always_comb begin
      rd_valid = valid[rd_idx];
      rd_tag   = tag_mem[rd_idx];
      rd_data  = data_mem[rd_idx];
   end

endmodule

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped read-only cache in front of main_memory, one request in flight.
// Hit answers 1 edge after LOOKUP entry; miss answers MEM_LATENCY+2 edges after the request edge.
// Optional hit/miss saturating counters are built only when CACHE_STATS_EN is defined.
module cache_controller
   import cache_pkg::*;
#(
   parameter int NUM_LINES   = 16,
   parameter int MEM_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cpu_req,
   input  logic [31:0]          cpu_addr,
   output logic [31:0]          cpu_rdata,
   output logic                 cpu_ready,
   output logic [31:0]          mem_addr,
   input  logic [LINE_BITS-1:0] mem_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]          hit_count,
   output logic [31:0]          miss_count
`endif
);

   localparam int IDX   = $clog2(NUM_LINES);
   localparam int TAG_W = 32 - OFFSET_BITS - IDX;
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   state_t             state, state_nxt;
   logic [31:0]        req_addr, req_addr_nxt;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
   logic [31:0]        rdata_nxt;
   logic               ready_nxt;
   logic [31:0]        mem_addr_nxt;
   logic               fill;
   logic               lookup_hit;
   logic               lookup_miss;

   logic                 rd_valid;
   logic [TAG_W-1:0]     rd_tag;
   logic [LINE_BITS-1:0] rd_data;
   logic [IDX-1:0]       req_idx;
   logic [TAG_W-1:0]     req_tag;

   assign req_idx = req_addr[OFFSET_BITS+IDX-1:OFFSET_BITS];
   assign req_tag = req_addr[31:OFFSET_BITS+IDX];

   cache_line_array #(
      .NUM_LINES (NUM_LINES),
      .IDX       (IDX),
      .TAG_W     (TAG_W)
   ) u_lines (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (req_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (fill),
      .wr_idx   (req_idx),
      .wr_tag   (req_tag),
      .wr_data  (mem_rdata)
   );

   // State and registered outputs; reset mid-miss drops the fill because nothing is written until capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_addr  <= '0;
         wait_cnt  <= '0;
         cpu_rdata <= '0;
         cpu_ready <= 1'b0;
         mem_addr  <= '0;
      end else begin
         state     <= state_nxt;
         req_addr  <= req_addr_nxt;
         wait_cnt  <= wait_cnt_nxt;
         cpu_rdata <= rdata_nxt;
         cpu_ready <= ready_nxt;
         mem_addr  <= mem_addr_nxt;
      end
   end

   // Next-state and next-output logic; cpu_req is only looked at in IDLE.
   always_comb begin
      state_nxt    = state;
      req_addr_nxt = req_addr;
      wait_cnt_nxt = wait_cnt;
      rdata_nxt    = cpu_rdata;
      ready_nxt    = 1'b0;
      mem_addr_nxt = mem_addr;
      fill         = 1'b0;
      lookup_hit   = 1'b0;
      lookup_miss  = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               req_addr_nxt = cpu_addr;
               state_nxt    = LOOKUP;
            end
         end
         LOOKUP: begin
            if (rd_valid && (rd_tag == req_tag)) begin
               lookup_hit = 1'b1;
               rdata_nxt  = word_sel(rd_data, req_addr[OFFSET_BITS-1:0]);
               ready_nxt  = 1'b1;
               state_nxt  = RESP;
            end else begin
               lookup_miss  = 1'b1;
               mem_addr_nxt = {req_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
               wait_cnt_nxt = CNT_W'(MEM_LATENCY);
               state_nxt    = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (wait_cnt != '0) begin
               wait_cnt_nxt = wait_cnt - 1'b1;
            end else begin
               fill      = 1'b1;
               rdata_nxt = word_sel(mem_rdata, req_addr[OFFSET_BITS-1:0]);
               ready_nxt = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef CACHE_STATS_EN
   // Saturating hit/miss counters, stepped once per LOOKUP outcome.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (lookup_hit && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
         end
         if (lookup_miss && (miss_count != 32'hFFFF_FFFF)) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: scoreboard bench for cache_controller with two instances (MEM_LATENCY 1 and 3).
// Memory model returns data word = its own byte address, delayed MEM_LATENCY edges after sampling.
// Expected responses are queued when a request is driven and checked when cpu_ready is seen.
module tb_cache_controller;

   typedef struct {
      int          dut;
      logic [31:0] data;
      int          cyc;
      logic [31:0] maddr;
   } sb_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cpu_req   [2];
   logic [31:0]  cpu_addr  [2];
   logic [31:0]  cpu_rdata [2];
   logic         cpu_ready [2];
   logic [31:0]  mem_addr  [2];
   logic [127:0] mem_rdata [2];
`ifdef CACHE_STATS_EN
   logic [31:0]  hit_count  [2];
   logic [31:0]  miss_count [2];
`endif

   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   sb_t sbq [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   cache_controller #(.NUM_LINES(16), .MEM_LATENCY(1)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req[0]),
      .cpu_addr  (cpu_addr[0]),
      .cpu_rdata (cpu_rdata[0]),
      .cpu_ready (cpu_ready[0]),
      .mem_addr  (mem_addr[0]),
      .mem_rdata (mem_rdata[0])
`ifdef CACHE_STATS_EN
      ,
      .hit_count  (hit_count[0]),
      .miss_count (miss_count[0])
`endif
   );

   cache_controller #(.NUM_LINES(16), .MEM_LATENCY(3)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req[1]),
      .cpu_addr  (cpu_addr[1]),
      .cpu_rdata (cpu_rdata[1]),
      .cpu_ready (cpu_ready[1]),
      .mem_addr  (mem_addr[1]),
      .mem_rdata (mem_rdata[1])
`ifdef CACHE_STATS_EN
      ,
      .hit_count  (hit_count[1]),
      .miss_count (miss_count[1])
`endif
   );

   // main_memory models: sample mem_addr each edge, present the line L edges later.
   for (genvar g = 0; g < 2; g++) begin : g_mem
      localparam int L = (g == 0) ? 1 : 3;
      logic [31:0] pipe [L];
      always @(posedge clk) begin
         pipe[0] <= mem_addr[g];
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign mem_rdata[g] = {pipe[L-1] + 32'd12, pipe[L-1] + 32'd8, pipe[L-1] + 32'd4, pipe[L-1]};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Response monitor: every cpu_ready must match the oldest queued expectation.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (cpu_ready[d] === 1'b1) begin
            if (sbq.size() == 0) begin
               chk($sformatf("spurious_ready_dut%0d", d), 32'd1, 32'd0);
            end else begin
               sb_t e;
               e = sbq.pop_front();
               chk("ready_dut", d, e.dut);
               chk("rdata", cpu_rdata[d], e.data);
               chk("ready_cycle", cyc, e.cyc);
               chk("mem_addr", mem_addr[d], e.maddr);
            end
         end
      end
   end

   // Wait (bounded) for the next cpu_ready on dut d.
   task automatic wait_ready(input int d);
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cpu_ready[d] === 1'b1) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         chk($sformatf("ready_timeout_dut%0d", d), 32'd0, 32'd1);
         sbq.delete();
      end
   endtask

   // One read: lat is the edge count after the sampling edge at which cpu_ready is expected.
   task automatic rd(input int d, input logic [31:0] a, input int lat, input logic [31:0] exp_maddr);
      sb_t e;
      @(negedge clk);
      cpu_req[d]  = 1'b1;
      cpu_addr[d] = a;
      @(posedge clk);
      #1;
      e.dut   = d;
      e.data  = a & 32'hFFFF_FFFC;
      e.cyc   = cyc + lat;
      e.maddr = exp_maddr;
      sbq.push_back(e);
      wait_ready(d);
      cpu_req[d] = 1'b0;
   endtask

   initial begin
      sb_t e;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         cpu_req[d]  = 1'b0;
         cpu_addr[d] = '0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", {31'd0, cpu_ready[d]}, 32'd0);
         chk("rst_rdata", cpu_rdata[d], 32'd0);
         chk("rst_mem_addr", mem_addr[d], 32'd0);
      end
      rst_n = 1'b1;

      // Cold miss then a hit in the same line.
      rd(0, 32'h0000_0104, 3, 32'h0000_0100);
      rd(0, 32'h0000_0108, 1, 32'h0000_0100);
`ifdef CACHE_STATS_EN
      chk("miss_count", miss_count[0], 32'd1);
      chk("hit_count", hit_count[0], 32'd1);
`endif

      // Longer memory latency: miss then hit.
      rd(1, 32'h0000_003C, 5, 32'h0000_0030);
      rd(1, 32'h0000_003C, 1, 32'h0000_0030);

      // Reset during MISS_WAIT abandons the fill.
      @(negedge clk);
      cpu_req[0]  = 1'b1;
      cpu_addr[0] = 32'h0000_0050;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("miss_wait_mem_addr", mem_addr[0], 32'h0000_0050);
      rst_n      = 1'b0;
      cpu_req[0] = 1'b0;
      #1;
      chk("midrst_ready", {31'd0, cpu_ready[0]}, 32'd0);
      chk("midrst_rdata", cpu_rdata[0], 32'd0);
      chk("midrst_mem_addr", mem_addr[0], 32'd0);
`ifdef CACHE_STATS_EN
      chk("midrst_miss_count", miss_count[0], 32'd0);
      chk("midrst_hit_count", hit_count[0], 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      rd(0, 32'h0000_0050, 3, 32'h0000_0050);

      // Conflicting lines at index 0 evict each other.
      rd(0, 32'h0000_0104, 3, 32'h0000_0100);
      rd(0, 32'h0000_0204, 3, 32'h0000_0200);
      rd(0, 32'h0000_0104, 3, 32'h0000_0100);

      // Request held through RESP with a new address: one response each, second sampled after RESP.
      @(negedge clk);
      cpu_req[0]  = 1'b1;
      cpu_addr[0] = 32'h0000_0108;
      @(posedge clk);
      #1;
      e.dut = 0; e.data = 32'h0000_0108; e.cyc = cyc + 1; e.maddr = 32'h0000_0100;
      sbq.push_back(e);
      e.dut = 0; e.data = 32'h0000_0104; e.cyc = cyc + 4; e.maddr = 32'h0000_0100;
      sbq.push_back(e);
      wait_ready(0);
      cpu_addr[0] = 32'h0000_0104;
      wait_ready(0);
      cpu_req[0] = 1'b0;

      repeat (8) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
